// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, one-hot bit positions, FSM states.
package alu_op_sequencer_pkg;

    localparam int unsigned OpcW   = 5;
    localparam int unsigned NumOps = 13;

    localparam logic [OpcW-1:0] OpcAdd  = 5'b00011;
    localparam logic [OpcW-1:0] OpcSub  = 5'b00100;
    localparam logic [OpcW-1:0] OpcAnd  = 5'b00101;
    localparam logic [OpcW-1:0] OpcOr   = 5'b00110;
    localparam logic [OpcW-1:0] OpcRor  = 5'b00111;
    localparam logic [OpcW-1:0] OpcRol  = 5'b01000;
    localparam logic [OpcW-1:0] OpcShr  = 5'b01001;
    localparam logic [OpcW-1:0] OpcShra = 5'b01010;
    localparam logic [OpcW-1:0] OpcShl  = 5'b01011;
    localparam logic [OpcW-1:0] OpcDiv  = 5'b01111;
    localparam logic [OpcW-1:0] OpcMul  = 5'b10000;
    localparam logic [OpcW-1:0] OpcNeg  = 5'b10001;
    localparam logic [OpcW-1:0] OpcNot  = 5'b10010;

    localparam int unsigned BitAdd  = 0;
    localparam int unsigned BitSub  = 1;
    localparam int unsigned BitMul  = 2;
    localparam int unsigned BitDiv  = 3;
    localparam int unsigned BitShr  = 4;
    localparam int unsigned BitShra = 5;
    localparam int unsigned BitShl  = 6;
    localparam int unsigned BitRor  = 7;
    localparam int unsigned BitRol  = 8;
    localparam int unsigned BitAnd  = 9;
    localparam int unsigned BitOr   = 10;
    localparam int unsigned BitNeg  = 11;
    localparam int unsigned BitNot  = 12;

    typedef enum logic [2:0] {
        StIdle,
        StLoadY,
        StExec,
        StWbLo,
        StWbHi,
        StErr
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot ALU select plus legality and operand/result-width flags.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [OpcW-1:0]   opcode,
    output logic [NumOps-1:0] op_onehot,
    output logic              legal,
    output logic              two_operand,
    output logic              wide_result
);

    always_comb begin
        op_onehot   = '0;
        legal       = 1'b1;
        two_operand = 1'b1;
        wide_result = 1'b0;
        case (opcode)
            OpcAdd:  op_onehot[BitAdd]  = 1'b1;
            OpcSub:  op_onehot[BitSub]  = 1'b1;
            OpcAnd:  op_onehot[BitAnd]  = 1'b1;
            OpcOr:   op_onehot[BitOr]   = 1'b1;
            OpcRor:  op_onehot[BitRor]  = 1'b1;
            OpcRol:  op_onehot[BitRol]  = 1'b1;
            OpcShr:  op_onehot[BitShr]  = 1'b1;
            OpcShra: op_onehot[BitShra] = 1'b1;
            OpcShl:  op_onehot[BitShl]  = 1'b1;
            OpcDiv: begin
                op_onehot[BitDiv] = 1'b1;
                wide_result       = 1'b1;
            end
            OpcMul: begin
                op_onehot[BitMul] = 1'b1;
                wide_result       = 1'b1;
            end
            OpcNeg: begin
                op_onehot[BitNeg] = 1'b1;
                two_operand       = 1'b0;
            end
            OpcNot: begin
                op_onehot[BitNot] = 1'b1;
                two_operand       = 1'b0;
            end
            default: begin
                legal       = 1'b0;
                two_operand = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences register-format ALU operations: load Y, execute with one-hot strobe, capture Z,
// write back Z-low (and Z-high for MUL/DIV).
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OPC_W   = OpcW,
    parameter int unsigned NUM_OPS = NumOps
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic [OPC_W-1:0]      opcode,
    input  logic [DATA_W-1:0]     bus_in,
    output logic                  bus_req_a,
    output logic                  bus_req_b,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [NUM_OPS-1:0]    alu_op,
    input  logic [2*DATA_W-1:0]   alu_c,
    output logic [DATA_W-1:0]     result_lo,
    output logic [DATA_W-1:0]     result_hi,
    output logic                  wr_lo,
    output logic                  wr_hi,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  div0
);

    state_e               state_q, state_d;
    logic [OPC_W-1:0]     opc_q, opc_d;
    logic [DATA_W-1:0]    y_q, y_d;
    logic [2*DATA_W-1:0]  z_q, z_d;

    logic                 bus_req_a_q, bus_req_a_d;
    logic                 bus_req_b_q, bus_req_b_d;
    logic [NUM_OPS-1:0]   alu_op_q, alu_op_d;
    logic                 wr_lo_q, wr_lo_d;
    logic                 wr_hi_q, wr_hi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [OPC_W-1:0]     dec_opc;
    logic [NUM_OPS-1:0]   dec_onehot;
    logic                 dec_legal;
    logic                 dec_two_op;
    logic                 dec_wide;

    // In IDLE the incoming opcode is checked; afterwards the latched one drives every decision.
    assign dec_opc = (state_q == StIdle) ? opcode : opc_q;

    alu_op_decode u_decode (
        .opcode      (dec_opc),
        .op_onehot   (dec_onehot),
        .legal       (dec_legal),
        .two_operand (dec_two_op),
        .wide_result (dec_wide)
    );

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        y_d     = y_q;
        z_d     = z_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (dec_legal) begin
                        state_d = StLoadY;
                        opc_d   = opcode;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StLoadY: begin
                y_d     = bus_in;
                state_d = StExec;
            end
            StExec: begin
                z_d     = alu_c;
                state_d = StWbLo;
            end
            StWbLo:  state_d = dec_wide ? StWbHi : StIdle;
            StWbHi:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered: each is decoded from the state being entered.
    always_comb begin
        bus_req_a_d = (state_d == StLoadY);
        bus_req_b_d = (state_d == StExec) && dec_two_op;
        alu_op_d    = (state_d == StExec) ? dec_onehot : '0;
        wr_lo_d     = (state_d == StWbLo);
        wr_hi_d     = (state_d == StWbHi);
        busy_d      = (state_d == StLoadY) || (state_d == StExec) ||
                      (state_d == StWbLo)  || (state_d == StWbHi);
        done_d      = (state_d == StWbHi) || ((state_d == StWbLo) && !dec_wide);
        err_d       = (state_d == StErr);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= StIdle;
            opc_q       <= '0;
            y_q         <= '0;
            z_q         <= '0;
            bus_req_a_q <= 1'b0;
            bus_req_b_q <= 1'b0;
            alu_op_q    <= '0;
            wr_lo_q     <= 1'b0;
            wr_hi_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            y_q         <= y_d;
            z_q         <= z_d;
            bus_req_a_q <= bus_req_a_d;
            bus_req_b_q <= bus_req_b_d;
            alu_op_q    <= alu_op_d;
            wr_lo_q     <= wr_lo_d;
            wr_hi_q     <= wr_hi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus_req_a = bus_req_a_q;
    assign bus_req_b = bus_req_b_q;
    assign alu_op    = alu_op_q;
    assign wr_lo     = wr_lo_q;
    assign wr_hi     = wr_hi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    assign alu_a     = y_q;
    assign alu_b     = bus_req_b_q ? bus_in : '0;
    assign result_lo = z_q[DATA_W-1:0];
    assign result_hi = z_q[2*DATA_W-1:DATA_W];
    assign div0      = (state_q == StExec) && alu_op_q[BitDiv] && (bus_in == '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU closing the loop on alu_c.
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] bus_in;
    logic        bus_req_a, bus_req_b;
    logic [31:0] alu_a, alu_b;
    logic [12:0] alu_op;
    logic [63:0] alu_c;
    logic [31:0] result_lo, result_hi;
    logic        wr_lo, wr_hi, busy, done, err, div0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_op_sequencer dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .opcode    (opcode),
        .bus_in    (bus_in),
        .bus_req_a (bus_req_a),
        .bus_req_b (bus_req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .wr_lo     (wr_lo),
        .wr_hi     (wr_hi),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .div0      (div0)
    );

    // Behavioural ALU; DIV returns {remainder, quotient}, zero on divide-by-zero.
    logic [63:0] dbl;
    logic [4:0]  sh;
    always_comb begin
        alu_c = '0;
        sh    = alu_b[4:0];
        dbl   = {alu_a, alu_a};
        case (1'b1)
            alu_op[0]:  alu_c[31:0] = alu_a + alu_b;
            alu_op[1]:  alu_c[31:0] = alu_a - alu_b;
            alu_op[2]:  alu_c = {32'd0, alu_a} * {32'd0, alu_b};
            alu_op[3]:  if (alu_b != 32'd0) alu_c = {alu_a % alu_b, alu_a / alu_b};
            alu_op[4]:  alu_c[31:0] = alu_a >> sh;
            alu_op[5]:  alu_c[31:0] = $signed(alu_a) >>> sh;
            alu_op[6]:  alu_c[31:0] = alu_a << sh;
            alu_op[7]:  alu_c[31:0] = 32'(dbl >> sh);
            alu_op[8]:  alu_c[31:0] = 32'((dbl << sh) >> 32);
            alu_op[9]:  alu_c[31:0] = alu_a & alu_b;
            alu_op[10]: alu_c[31:0] = alu_a | alu_b;
            alu_op[11]: alu_c[31:0] = 32'd0 - alu_a;
            alu_op[12]: alu_c[31:0] = ~alu_a;
            default:    alu_c = '0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  opc;
        int          bidx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        wide;
        logic        two_op;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    task automatic run_vec(input int i, input vec_t v);
        logic [12:0] exp_op;
        exp_op = 13'd1 << v.bidx;
        start  = 1'b1;
        opcode = v.opc;
        bus_in = 32'd0;
        @(posedge clock); #1;
        start = 1'b0;
        check($sformatf("v%0d load busy", i), 64'(busy), 64'd1);
        check($sformatf("v%0d load bus_req_a", i), 64'(bus_req_a), 64'd1);
        check($sformatf("v%0d load alu_op", i), 64'(alu_op), 64'd0);
        bus_in = v.a;
        @(posedge clock); #1;
        bus_in = v.two_op ? v.b : 32'hDEAD_BEEF;
        #1;
        check($sformatf("v%0d exec alu_op", i), 64'(alu_op), 64'(exp_op));
        check($sformatf("v%0d exec bus_req_b", i), 64'(bus_req_b), 64'(v.two_op));
        check($sformatf("v%0d exec alu_a", i), 64'(alu_a), 64'(v.a));
        check($sformatf("v%0d exec alu_b", i), 64'(alu_b), 64'(v.two_op ? v.b : 32'd0));
        check($sformatf("v%0d exec div0", i), 64'(div0), 64'(v.dz));
        @(posedge clock); #1;
        check($sformatf("v%0d wblo wr_lo", i), 64'(wr_lo), 64'd1);
        check($sformatf("v%0d wblo wr_hi", i), 64'(wr_hi), 64'd0);
        check($sformatf("v%0d wblo result_lo", i), 64'(result_lo), 64'(v.lo));
        check($sformatf("v%0d wblo done", i), 64'(done), 64'(!v.wide));
        check($sformatf("v%0d wblo alu_op", i), 64'(alu_op), 64'd0);
        if (v.wide) begin
            @(posedge clock); #1;
            check($sformatf("v%0d wbhi wr_hi", i), 64'(wr_hi), 64'd1);
            check($sformatf("v%0d wbhi wr_lo", i), 64'(wr_lo), 64'd0);
            check($sformatf("v%0d wbhi done", i), 64'(done), 64'd1);
        end
        check($sformatf("v%0d result_hi", i), 64'(result_hi), 64'(v.hi));
        @(posedge clock); #1;
        check($sformatf("v%0d idle busy", i), 64'(busy), 64'd0);
        check($sformatf("v%0d idle done", i), 64'(done), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " err"}, 64'(err), 64'd0);
        check({tag, " wr_lo"}, 64'(wr_lo), 64'd0);
        check({tag, " wr_hi"}, 64'(wr_hi), 64'd0);
        check({tag, " alu_op"}, 64'(alu_op), 64'd0);
        check({tag, " bus_req_a"}, 64'(bus_req_a), 64'd0);
        check({tag, " bus_req_b"}, 64'(bus_req_b), 64'd0);
        check({tag, " alu_a"}, 64'(alu_a), 64'd0);
        check({tag, " alu_b"}, 64'(alu_b), 64'd0);
        check({tag, " result_lo"}, 64'(result_lo), 64'd0);
        check({tag, " result_hi"}, 64'(result_hi), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcount;
        int strobes;
        logic exp_busy;

        vecs[0]  = '{5'b00011, 0,  32'd5,          32'd7,        32'd12,         32'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{5'b00100, 1,  32'd10,         32'd3,        32'd7,          32'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{5'b00101, 9,  32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000, 32'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{5'b00110, 10, 32'h0000_00F0,  32'h0000_000F, 32'h0000_00FF, 32'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{5'b00111, 7,  32'h0000_0001,  32'd1,        32'h8000_0000,  32'd0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{5'b01000, 8,  32'h8000_0001,  32'd4,        32'h0000_0018,  32'd0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{5'b01001, 4,  32'h8000_0000,  32'd4,        32'h0800_0000,  32'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{5'b01010, 5,  32'h8000_0000,  32'd4,        32'hF800_0000,  32'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{5'b01011, 6,  32'd3,          32'd2,        32'd12,         32'd0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{5'b10000, 2,  32'h0001_0000,  32'h0001_0000, 32'd0,         32'd1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{5'b01111, 3,  32'd7,          32'd0,        32'd0,          32'd0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{5'b01111, 3,  32'd17,         32'd5,        32'd3,          32'd2, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{5'b10001, 11, 32'd1,          32'd0,        32'hFFFF_FFFF,  32'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{5'b10010, 12, 32'd0,          32'd0,        32'hFFFF_FFFF,  32'd0, 1'b0, 1'b0, 1'b0};

        clear_n = 1'b0;
        start   = 1'b0;
        opcode  = 5'd0;
        bus_in  = 32'd0;
        @(posedge clock); #1;
        check_all_zero("reset");
        clear_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Illegal opcode: err pulse, nothing else.
        start  = 1'b1;
        opcode = 5'b11111;
        @(posedge clock); #1;
        start = 1'b0;
        check("illegal err", 64'(err), 64'd1);
        check("illegal busy", 64'(busy), 64'd0);
        check("illegal alu_op", 64'(alu_op), 64'd0);
        @(posedge clock); #1;
        check("illegal err end", 64'(err), 64'd0);
        check("illegal busy end", 64'(busy), 64'd0);
        check("illegal alu_op end", 64'(alu_op), 64'd0);

        // Back-to-back with start held high: accept, done at k=2, idle k=3, re-accept, done at k=6.
        start  = 1'b1;
        opcode = 5'b00011;
        bus_in = 32'd0;
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (k == 7) start = 1'b0;
            exp_busy = (k == 0) || (k == 1) || (k == 2) || (k == 4) || (k == 5) || (k == 6);
            check($sformatf("b2b k%0d done", k), 64'(done), 64'((k == 2) || (k == 6)));
            check($sformatf("b2b k%0d busy", k), 64'(busy), 64'(exp_busy));
            if (done) begin
                dcount++;
                check($sformatf("b2b k%0d result_lo", k), 64'(result_lo), 64'd12);
            end
            bus_in = bus_req_a ? 32'd5 : 32'd7;
        end
        start = 1'b0;
        check("b2b done count", 64'(dcount), 64'd2);

        // Reset asserted mid-EXEC.
        start  = 1'b1;
        opcode = 5'b00011;
        @(posedge clock); #1;
        start  = 1'b0;
        bus_in = 32'd9;
        @(posedge clock); #1;
        bus_in = 32'd4;
        check("midrst in exec", 64'(alu_op), 64'd1);
        clear_n = 1'b0;
        #1;
        bus_in = 32'd0;
        check_all_zero("midrst async");
        @(posedge clock); #1;
        check_all_zero("midrst held");
        clear_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            strobes += int'(wr_lo) + int'(wr_hi) + int'(done) + int'(busy);
        end
        check("midrst no strobes after release", 64'(strobes), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
